// File: rtl/fire_seq_pkg.sv
// -----------------------------------------------------------------------------
// fire_seq_pkg
// Shared types and default timing for the fire sequencer.
//   seq_state_t  : sequencer state, also driven onto state_dbg for the LED mux
//   fault_code_t : reason the sequencer is sitting in FAULT
//   *_DEF        : default timing parameters (timing values are in ticks)
// -----------------------------------------------------------------------------
package fire_seq_pkg;

  typedef enum logic [2:0] {
    IDLE, AIM, CHARGE, SETTLE, FIRE, COOLDOWN, FAULT
  } seq_state_t;

  typedef enum logic [1:0] {
    FC_NONE        = 2'b00,
    FC_ESTOP       = 2'b01,
    FC_AIM_TIMEOUT = 2'b10,
    FC_DISARMED    = 2'b11
  } fault_code_t;

  localparam int unsigned TICK_DIV_DEF     = 2**24;
  localparam logic [7:0]  AIM_TIMEOUT_DEF  = 8'd60;
  localparam logic [7:0]  SETTLE_TICKS_DEF = 8'd2;
  localparam logic [7:0]  FIRE_TICKS_DEF   = 8'd5;
  localparam logic [7:0]  COOL_TICKS_DEF   = 8'd10;

endpackage

// File: rtl/fire_sequencer_if.sv
// -----------------------------------------------------------------------------
// fire_sequencer_if
// Command, interlock and relay signals between the SPI command register /
// operator panel (master) and the fire sequencer (slave).
//   command  : cmd_valid, cmd_ready, cmd_force
//   operator : armed, emergencyStop, clear_fault
//   axes     : aziDone, polDone, aim_load
//   relays   : comp_relay, solenoid_relay
//   status   : busy, fault, fault_code, state_dbg
// Build option SHOT_COUNTER_EN adds the 16-bit shot_count status output.
// -----------------------------------------------------------------------------
interface fire_sequencer_if;
  import fire_seq_pkg::*;

  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_force;
  logic        armed;
  logic        emergencyStop;
  logic        clear_fault;
  logic        aziDone;
  logic        polDone;
  logic        aim_load;
  logic        comp_relay;
  logic        solenoid_relay;
  logic        busy;
  logic        fault;
  fault_code_t fault_code;
  seq_state_t  state_dbg;
`ifdef SHOT_COUNTER_EN
  logic [15:0] shot_count;
`endif

  modport master (
    output cmd_valid, cmd_force, armed, emergencyStop, clear_fault, aziDone, polDone,
    input  cmd_ready, aim_load, comp_relay, solenoid_relay, busy, fault, fault_code,
`ifdef SHOT_COUNTER_EN
    input  shot_count,
`endif
    input  state_dbg
  );

  modport slave (
    input  cmd_valid, cmd_force, armed, emergencyStop, clear_fault, aziDone, polDone,
    output cmd_ready, aim_load, comp_relay, solenoid_relay, busy, fault, fault_code,
`ifdef SHOT_COUNTER_EN
    output shot_count,
`endif
    output state_dbg
  );

endinterface

// File: rtl/seq_timer.sv
// -----------------------------------------------------------------------------
// seq_timer
// Tick prescaler plus an 8-bit loadable down-counter of ticks.
//   clk, rst     : clock, asynchronous active-high reset
//   i_load       : restart the prescaler and load i_load_val into the counter
//   i_load_val   : interval length in ticks
//   o_tick       : one-clk strobe every TICK_DIV clks
//   o_expired    : interval ends on the current tick (valid qualified by o_tick)
// Restarting the prescaler on load makes every interval exactly N*TICK_DIV
// clks long; a load of 0 ends on the first tick, same as a load of 1.
// -----------------------------------------------------------------------------
module seq_timer #(
  parameter int unsigned TICK_DIV = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_load,
  input  logic [7:0] i_load_val,
  output logic       o_tick,
  output logic       o_expired
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0] r_pre;
  logic [7:0]    r_cnt;

  assign o_tick    = (r_pre == PW'(TICK_DIV - 1));
  assign o_expired = (r_cnt <= 8'd1);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and simulation order cannot change the result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pre <= '0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_pre <= '0;
      r_cnt <= i_load_val;
    end else if (o_tick) begin
      r_pre <= '0;
      if (r_cnt != 8'd0) r_cnt <= r_cnt - 8'd1;
    end else begin
      r_pre <= r_pre + PW'(1);
    end
  end

endmodule

// File: rtl/fire_sequencer.sv
// -----------------------------------------------------------------------------
// fire_sequencer
// Ordered, interlocked shot controller: AIM -> CHARGE -> SETTLE -> FIRE ->
// COOLDOWN, with FAULT on emergency stop, aim timeout or disarm at fire.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : fire_sequencer_if.slave (command, operator, axes, relays, status)
// Build option SHOT_COUNTER_EN adds a saturating count of FIRE entries on
// bus.shot_count; without it the counter does not exist.
// Outputs are registered from the next state; the two relays are further
// gated by emergencyStop so they drop in the same cycle the stop rises.
// -----------------------------------------------------------------------------
module fire_sequencer
  import fire_seq_pkg::*;
#(
  parameter int unsigned TICK_DIV     = TICK_DIV_DEF,
  parameter logic [7:0]  AIM_TIMEOUT  = AIM_TIMEOUT_DEF,
  parameter logic [7:0]  SETTLE_TICKS = SETTLE_TICKS_DEF,
  parameter logic [7:0]  FIRE_TICKS   = FIRE_TICKS_DEF,
  parameter logic [7:0]  COOL_TICKS   = COOL_TICKS_DEF
) (
  input  logic           clk,
  input  logic           rst,
  fire_sequencer_if.slave bus
);

  seq_state_t  r_state, w_next;
  fault_code_t r_code, w_code;
  logic [7:0]  r_force;
  logic        r_cmd_ready, r_busy, r_fault, r_aim_load, r_comp, r_sol;
  logic        w_load, w_tick, w_expired, w_timeout, w_aimed;
  logic [7:0]  w_load_val;

  seq_timer #(.TICK_DIV(TICK_DIV)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_tick     (w_tick),
    .o_expired  (w_expired)
  );

  assign w_timeout = w_tick && w_expired;
  assign w_aimed   = bus.aziDone && bus.polDone;

  // Priority: emergency stop, then timer expiry, then done/advance.
  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    w_next     = r_state;
    w_code     = r_code;
    w_load     = 1'b0;
    w_load_val = 8'd0;
    if (r_state != IDLE && bus.emergencyStop) begin
      w_next = FAULT;
      w_code = FC_ESTOP;
    end else begin
      case (r_state)
        IDLE: if (bus.cmd_valid && r_cmd_ready && !bus.emergencyStop) begin
          w_next = AIM; w_code = FC_NONE; w_load = 1'b1; w_load_val = AIM_TIMEOUT;
        end
        AIM: if (w_timeout) begin
          w_next = FAULT; w_code = FC_AIM_TIMEOUT;
        end else if (w_aimed) begin
          w_next = CHARGE; w_load = 1'b1; w_load_val = r_force;
        end
        // A zero force leaves CHARGE on the next clk without waiting for a tick.
        CHARGE: if (r_force == 8'd0 || w_timeout) begin
          w_next = SETTLE; w_load = 1'b1; w_load_val = SETTLE_TICKS;
        end
        SETTLE: if (w_timeout) begin
          if (!bus.armed) begin
            w_next = FAULT; w_code = FC_DISARMED;
          end else if (w_aimed) begin
            w_next = FIRE; w_load = 1'b1; w_load_val = FIRE_TICKS;
          end else begin
            w_next = AIM; w_load = 1'b1; w_load_val = AIM_TIMEOUT;
          end
        end
        FIRE: if (w_timeout) begin
          w_next = COOLDOWN; w_load = 1'b1; w_load_val = COOL_TICKS;
        end
        COOLDOWN: if (w_timeout) w_next = IDLE;
        FAULT: if (bus.clear_fault) begin
          w_next = IDLE; w_code = FC_NONE;
        end
        default: w_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_code      <= FC_NONE;
      r_force     <= 8'd0;
      r_cmd_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_fault     <= 1'b0;
      r_aim_load  <= 1'b0;
      r_comp      <= 1'b0;
      r_sol       <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_code      <= w_code;
      if (r_state == IDLE && w_next == AIM) r_force <= bus.cmd_force;
      r_cmd_ready <= (w_next == IDLE);
      r_busy      <= (w_next != IDLE);
      r_fault     <= (w_next == FAULT);
      r_aim_load  <= (w_next inside {AIM, CHARGE, SETTLE, FIRE});
      r_comp      <= (w_next == CHARGE) && (r_force != 8'd0);
      r_sol       <= (w_next == FIRE);
    end
  end

`ifdef SHOT_COUNTER_EN
  logic [15:0] r_shot_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shot_count <= 16'd0;
    end else if (w_next == FIRE && r_state != FIRE && r_shot_count != 16'hFFFF) begin
      r_shot_count <= r_shot_count + 16'd1;
    end
  end

  assign bus.shot_count = r_shot_count;
`endif

  assign bus.cmd_ready      = r_cmd_ready;
  assign bus.busy           = r_busy;
  assign bus.fault          = r_fault;
  assign bus.fault_code     = r_code;
  assign bus.state_dbg      = r_state;
  assign bus.aim_load       = r_aim_load;
  assign bus.comp_relay     = r_comp && !bus.emergencyStop;
  assign bus.solenoid_relay = r_sol && !bus.emergencyStop;

  a_interlock: assert property (@(posedge clk) disable iff (rst)
    !(bus.comp_relay && bus.solenoid_relay));

endmodule
